mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs in the pipelined MIPS core.
- Converts a latched load/store into a req/ack transaction on a multi-cycle data-memory bus, and handles byte lanes and load extension.
- Stalls the pipeline until the access completes.
- Returns extended load data to the MEM/WB register.

---
 rtl/mips_mem_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
// Optional build macro used by the unit: MEM_MISALIGN_TRAP_EN.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_TO_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // Bus payload held stable for the whole BUSY phase.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_bus_t;

    // True when the low address bits do not fit the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated data, and load
// byte/half selection with sign or zero extension (little-endian lanes).
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_a_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_a_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store lanes; misaligned halves/words fall back to their natural lane.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = st_data_i;
        case (st_size_i)
            SZ_BYTE: begin
                be_c    = 4'b0001 << st_a_i;
                wdata_c = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_c    = st_a_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = rdata_i[{ld_a_i, 3'b000} +: 8];
    assign ld_half = ld_a_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        ld_data_c = rdata_i;
        case (ld_size_i)
            SZ_BYTE: ld_data_c = ld_unsigned_i ? {24'h000000, ld_byte}
                                               : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_c = ld_unsigned_i ? {16'h0000, ld_half}
                                               : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns an EX/MEM access into a req/ack bus
// transaction, stalls the pipe meanwhile. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TO_W           = DEF_TO_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_out,
    input  logic [31:0] r2_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_exc
`endif
);

    mem_state_e      state_q, state_d;
    dmem_bus_t       bus_q, bus_d;
    logic            req_q, req_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      a_q, a_d;
    logic            uns_q, uns_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]     load_data_q, load_data_d;
    logic            load_valid_q, load_valid_d;
    logic            bus_err_q, bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    logic        access;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ld_data_c;

    assign access = op_valid & (mem_read | mem_write);

    // Store lanes come from live EX/MEM; load extraction uses the latched request.
    mem_lane_align u_lane (
        .st_size_i     (mem_size),
        .st_a_i        (alu_out[1:0]),
        .st_data_i     (r2_out),
        .be_c          (be_c),
        .wdata_c       (wdata_c),
        .ld_size_i     (size_q),
        .ld_a_i        (a_q),
        .ld_unsigned_i (uns_q),
        .rdata_i       (dmem_rdata),
        .ld_data_c     (ld_data_c)
    );

    always_comb begin
        state_d      = state_q;
        bus_d        = bus_q;
        req_d        = req_q;
        size_d       = size_q;
        a_d          = a_q;
        uns_d        = uns_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        mem_stall    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    mem_stall   = 1'b1;
                    bus_d.we    = mem_write;
                    bus_d.addr  = {alu_out[31:2], 2'b00};
                    bus_d.be    = be_c;
                    bus_d.wdata = wdata_c;
                    size_d      = mem_size;
                    a_d         = alu_out[1:0];
                    uns_d       = mem_unsigned;
                    cnt_d       = '0;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (is_misaligned(mem_size, alu_out[1:0])) begin
                        bus_d.we     = 1'b0;
                        bus_d.be     = 4'b0000;
                        load_data_d  = '0;
                        load_valid_d = ~mem_write;
                        misalign_d   = 1'b1;
                        state_d      = ST_DONE;
                    end else
`endif
                    begin
                        req_d   = 1'b1;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    req_d        = 1'b0;
                    bus_d.we     = 1'b0;
                    bus_d.be     = 4'b0000;
                    load_valid_d = ~bus_q.we;
                    if (!bus_q.we) begin
                        load_data_d = ld_data_c;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abort: report through bus_err and a zero load result.
                    req_d        = 1'b0;
                    bus_d.we     = 1'b0;
                    bus_d.be     = 4'b0000;
                    load_data_d  = '0;
                    load_valid_d = ~bus_q.we;
                    bus_err_d    = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bus_q        <= '0;
            req_q        <= 1'b0;
            size_q       <= SZ_BYTE;
            a_q          <= 2'b00;
            uns_q        <= 1'b0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_q        <= bus_d;
            req_q        <= req_d;
            size_q       <= size_d;
            a_q          <= a_d;
            uns_q        <= uns_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_exc = misalign_q;
`endif

    assign dmem_req   = req_q;
    assign dmem_we    = bus_q.we;
    assign dmem_addr  = bus_q.addr;
    assign dmem_be    = bus_q.be;
    assign dmem_wdata = bus_q.wdata;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected bus
// requests and completions, a negedge monitor pops and compares them.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] alu_out, r2_out;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, load_valid, bus_err;
    logic [31:0] load_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    mem_access_unit #(.TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .alu_out      (alu_out),
        .r2_out       (r2_out),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .mem_stall    (mem_stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .bus_err      (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_exc (misalign_exc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        err;
        int          stall;
    } done_exp_t;

    req_exp_t  exp_req_q[$];
    done_exp_t exp_done_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic     mon_en = 1'b1;
    logic     prev_req = 1'b0;
    logic     prev_stall = 1'b0;
    logic     done_ev;
    int       stall_cnt = 0;
    req_exp_t cur_r;
    done_exp_t cur_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic miss(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event with empty expectation queue at %0t", nm, $time);
    endtask

    // Monitor: compare request launches, held requests and completions.
    always @(negedge clk) begin
        done_ev = 1'b0;
        if (mon_en && reset) begin
            if (dmem_req && !prev_req) begin
                if (exp_req_q.size() == 0) begin
                    miss("unexpected_req");
                end else begin
                    cur_r = exp_req_q.pop_front();
                    chk("req_we", 32'(dmem_we), 32'(cur_r.we));
                    chk("req_addr", dmem_addr, cur_r.addr);
                    chk("req_be", 32'(dmem_be), 32'(cur_r.be));
                    if (cur_r.we) chk("req_wdata", dmem_wdata, cur_r.wdata);
                end
            end else if (dmem_req) begin
                chk("hold_bus", {dmem_addr[31:4], dmem_be}, {cur_r.addr[31:4], cur_r.be});
                chk("hold_we", 32'(dmem_we), 32'(cur_r.we));
            end
            if (mem_stall) begin
                stall_cnt++;
            end else if (prev_stall) begin
                done_ev = 1'b1;
                if (exp_done_q.size() == 0) begin
                    miss("unexpected_done");
                end else begin
                    cur_d = exp_done_q.pop_front();
                    chk("done_stall_cycles", 32'(stall_cnt), 32'(cur_d.stall));
                    chk("done_load_valid", 32'(load_valid), 32'(cur_d.lv));
                    chk("done_bus_err", 32'(bus_err), 32'(cur_d.err));
                    chk("done_req_low", 32'(dmem_req), 32'h0);
                    if (cur_d.lv) chk("done_load_data", load_data, cur_d.ld);
                end
                stall_cnt = 0;
            end
            if (!done_ev) chk("no_stray_pulse", {30'h0, load_valid, bus_err}, 32'h0);
        end else begin
            stall_cnt = 0;
        end
        prev_req   = dmem_req;
        prev_stall = mem_stall;
    end

    // Issue one access, answer the bus after ack_after BUSY cycles (0 = never).
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_after, input logic [31:0] rdata, input logic hold,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic [31:0] e_ld,
                          input logic e_err, input int e_stall);
        req_exp_t  r;
        done_exp_t d;
        logic      found;
        r.we = wr; r.addr = e_addr; r.be = e_be; r.wdata = e_wd;
        d.lv = ~wr; d.ld = e_ld; d.err = e_err; d.stall = e_stall;
        exp_req_q.push_back(r);
        exp_done_q.push_back(d);
        op_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
        mem_unsigned = uns; alu_out = addr; r2_out = wd;
        found = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            if (!mem_stall) begin
                found = 1'b1;
                break;
            end
            dmem_ack   = (ack_after == k);
            dmem_rdata = (ack_after == k) ? rdata : 32'hDEADBEEF;
        end
        dmem_ack = 1'b0;
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL op_complete: stall never released for addr 0x%08h", addr);
        end
        @(posedge clk); #1;
        if (!hold) begin
            op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        end
    endtask

    initial begin
        req_exp_t r;
        reset = 1'b0;
        op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = SZ_BYTE;
        mem_unsigned = 1'b0; alu_out = '0; r2_out = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_bus", {dmem_addr[31:5], dmem_we, dmem_be}, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_flags", {29'h0, load_valid, bus_err, mem_stall}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // sb / lb / lbu / lh / lhu / sh
        run_op(0, 1, SZ_BYTE, 0, 32'h1003, 32'h000000AB, 1, 32'h0, 0,
               32'h1000, 4'b1000, 32'hABABABAB, 32'h0, 0, 2);
        run_op(1, 0, SZ_BYTE, 0, 32'h2001, 32'h0, 3, 32'h12348000, 0,
               32'h2000, 4'b0010, 32'h0, 32'hFFFFFF80, 0, 4);
        run_op(1, 0, SZ_BYTE, 1, 32'h2001, 32'h0, 3, 32'h12348000, 0,
               32'h2000, 4'b0010, 32'h0, 32'h00000080, 0, 4);
        run_op(1, 0, SZ_HALF, 0, 32'h2002, 32'h0, 2, 32'h8001FFFF, 0,
               32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 0, 3);
        run_op(1, 0, SZ_HALF, 1, 32'h2002, 32'h0, 2, 32'h8001FFFF, 0,
               32'h2000, 4'b1100, 32'h0, 32'h00008001, 0, 3);
        run_op(0, 1, SZ_HALF, 0, 32'h4001, 32'h1234BEEF, 1, 32'h0, 0,
               32'h4000, 4'b0011, 32'hBEEFBEEF, 32'h0, 0, 2);

        // Back-to-back sw then lw with op_valid held
        run_op(0, 1, SZ_WORD, 0, 32'h5006, 32'hCAFEF00D, 1, 32'h0, 1,
               32'h5004, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 2);
        run_op(1, 0, SZ_WORD, 1, 32'h5004, 32'h0, 2, 32'h89ABCDEF, 0,
               32'h5004, 4'b1111, 32'h0, 32'h89ABCDEF, 0, 3);

        // read and write both set: one store only
        run_op(1, 1, SZ_WORD, 0, 32'h6000, 32'h11223344, 1, 32'h55667788, 0,
               32'h6000, 4'b1111, 32'h11223344, 32'h0, 0, 2);

        // Timeout abort of a load
        run_op(1, 0, SZ_WORD, 0, 32'h7000, 32'h0, 0, 32'h0, 0,
               32'h7000, 4'b1111, 32'h0, 32'h0, 1, 1 + TMO);

        // Top byte, positive sign; size 11 as word
        run_op(1, 0, SZ_BYTE, 0, 32'h8003, 32'h0, 1, 32'h7F000000, 0,
               32'h8000, 4'b1000, 32'h0, 32'h0000007F, 0, 2);
        run_op(1, 0, 2'b11, 0, 32'h9002, 32'h0, 1, 32'hF0F0F0F0, 0,
               32'h9000, 4'b1111, 32'h0, 32'hF0F0F0F0, 0, 2);

        // Bubbles and stray acks must not start anything
        op_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        #1 chk("bubble_no_stall", 32'(mem_stall), 32'h0);
        @(posedge clk); #1;
        op_valid = 1'b0; mem_read = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF;
        #1 chk("invalid_no_stall", 32'(mem_stall), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ack_ignored", {30'h0, dmem_req, load_valid}, 32'h0);
        dmem_ack = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;

        // Reset during BUSY cycle 2, then a late ack
        r.we = 1'b0; r.addr = 32'h3000; r.be = 4'b1111; r.wdata = 32'h0;
        exp_req_q.push_back(r);
        op_valid = 1'b1; mem_read = 1'b1; mem_size = SZ_WORD; alu_out = 32'h3000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy2_req", 32'(dmem_req), 32'h1);
        mon_en = 1'b0;
        #1;
        reset = 1'b0; op_valid = 1'b0; mem_read = 1'b0;
        #1;
        chk("areset_req", 32'(dmem_req), 32'h0);
        chk("areset_bus", {dmem_addr[31:5], dmem_we, dmem_be}, 32'h0);
        chk("areset_wdata", dmem_wdata, 32'h0);
        chk("areset_load", load_data, 32'h0);
        chk("areset_flags", {29'h0, load_valid, bus_err, mem_stall}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_ignored", {29'h0, dmem_req, load_valid, mem_stall}, 32'h0);
        chk("late_ack_load", load_data, 32'h0);
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("req_queue_drained", 32'(exp_req_q.size()), 32'h0);
        chk("done_queue_drained", 32'(exp_done_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
